// File: rtl/dram_cmd_scheduler.sv
// Single-request DRAM command scheduler with per-bank open-row tracking and
// refresh handling. One request is in flight at a time; commands are issued
// from registers one cycle after the decision that produced them.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | waiting; refresh wins over a pending request
// PRE         | precharge of the target bank is on the command bus
// WAIT_RP     | precharge recovery before ACT
// ACT         | activate of the target bank/row is on the command bus
// WAIT_RCD    | activate-to-access delay
// ACCESS      | read/write is on the command bus
// PREA        | precharge-all is on the command bus (refresh path)
// WAIT_RP_REF | precharge recovery before REF
// REF         | refresh is on the command bus
// WAIT_RFC    | refresh in progress; ack on the last cycle
module dram_cmd_scheduler #(
  parameter  int NUM_OF_BANKS = 8,
  parameter  int NUM_OF_ROWS  = 128,
  parameter  int NUM_OF_COLS  = 8,
  parameter  int T_RCD        = 2,
  parameter  int T_RP         = 2,
  parameter  int T_RFC        = 8,
  localparam int BW           = $clog2(NUM_OF_BANKS),
  localparam int RW           = $clog2(NUM_OF_ROWS),
  localparam int CW           = $clog2(NUM_OF_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [BW-1:0] req_bank,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  input  logic          req_we,
  input  logic          refresh_req,
  output logic          refresh_ack,
  output logic          cmd_valid,
  output logic [1:0]    cmd,
  output logic          cmd_all,
  output logic [BW-1:0] cmd_bank,
  output logic [RW-1:0] cmd_row,
  output logic [CW-1:0] cmd_col,
  output logic          cmd_we,
  output logic          busy
);

  localparam int T_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                        : ((T_RP > T_RFC) ? T_RP : T_RFC);
  localparam int CNTW  = $clog2(T_MAX + 1);

  // Wait states are entered one cycle after the command, so they last T-1 cycles.
  localparam logic [CNTW-1:0] RCD_LOAD = CNTW'((T_RCD > 1) ? T_RCD - 2 : 0);
  localparam logic [CNTW-1:0] RP_LOAD  = CNTW'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [CNTW-1:0] RFC_LOAD = CNTW'(T_RFC - 1);

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RW  = 2'b01;
  localparam logic [1:0] CMD_PRE = 2'b10;
  localparam logic [1:0] CMD_REF = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_ACCESS,
    S_PREA, S_WAIT_RP_REF, S_REF, S_WAIT_RFC
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
  logic              w_issue, w_all, w_accept, w_hit;
  logic [1:0]        w_code;
  logic [BW-1:0]     r_req_bank, w_bank;
  logic [RW-1:0]     r_req_row, w_row;
  logic [CW-1:0]     r_req_col, w_col;
  logic              r_req_we, w_we;
  logic [NUM_OF_BANKS-1:0] r_open;
  logic [RW-1:0]     r_open_row [NUM_OF_BANKS];
  logic              r_cmd_valid, r_cmd_all, r_cmd_we;
  logic [1:0]        r_cmd;
  logic [BW-1:0]     r_cmd_bank;
  logic [RW-1:0]     r_cmd_row;
  logic [CW-1:0]     r_cmd_col;

  // Command address comes straight from the request on the accept cycle.
  assign w_hit  = r_open[req_bank] && (r_open_row[req_bank] == req_row);
  assign w_bank = w_accept ? req_bank : r_req_bank;
  assign w_row  = w_accept ? req_row  : r_req_row;
  assign w_col  = w_accept ? req_col  : r_req_col;
  assign w_we   = w_accept ? req_we   : r_req_we;

  assign req_ready   = (r_state == S_IDLE) && !refresh_req && !rst;
  assign busy        = (r_state != S_IDLE) && !rst;
  assign refresh_ack = (r_state == S_WAIT_RFC) && (r_cnt == '0) && !rst;
  assign cmd_valid   = r_cmd_valid && !rst;
  assign cmd         = rst ? '0 : r_cmd;
  assign cmd_all     = r_cmd_all && !rst;
  assign cmd_bank    = rst ? '0 : r_cmd_bank;
  assign cmd_row     = rst ? '0 : r_cmd_row;
  assign cmd_col     = rst ? '0 : r_cmd_col;
  assign cmd_we      = r_cmd_we && !rst;

  // Next state, counter reload and the command to register for next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    w_all       = 1'b0;
    w_accept    = 1'b0;
    w_code      = CMD_ACT;
    unique case (r_state)
      S_IDLE: begin
        if (refresh_req) begin
          w_issue = 1'b1;
          if (|r_open) begin
            w_state_nxt = S_PREA;
            w_code      = CMD_PRE;
            w_all       = 1'b1;
          end else begin
            w_state_nxt = S_REF;
            w_code      = CMD_REF;
          end
        end else if (req_valid) begin
          w_accept = 1'b1;
          w_issue  = 1'b1;
          if (w_hit) begin
            w_state_nxt = S_ACCESS;
            w_code      = CMD_RW;
          end else if (r_open[req_bank]) begin
            w_state_nxt = S_PRE;
            w_code      = CMD_PRE;
          end else begin
            w_state_nxt = S_ACT;
            w_code      = CMD_ACT;
          end
        end
      end
      S_PRE, S_WAIT_RP: begin
        if ((r_state == S_PRE && T_RP == 1) || (r_state == S_WAIT_RP && r_cnt == '0)) begin
          w_state_nxt = S_ACT;
          w_issue     = 1'b1;
          w_code      = CMD_ACT;
        end else if (r_state == S_PRE) begin
          w_state_nxt = S_WAIT_RP;
          w_cnt_nxt   = RP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ACT, S_WAIT_RCD: begin
        if ((r_state == S_ACT && T_RCD == 1) || (r_state == S_WAIT_RCD && r_cnt == '0)) begin
          w_state_nxt = S_ACCESS;
          w_issue     = 1'b1;
          w_code      = CMD_RW;
        end else if (r_state == S_ACT) begin
          w_state_nxt = S_WAIT_RCD;
          w_cnt_nxt   = RCD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ACCESS: w_state_nxt = S_IDLE;
      S_PREA, S_WAIT_RP_REF: begin
        if ((r_state == S_PREA && T_RP == 1) || (r_state == S_WAIT_RP_REF && r_cnt == '0)) begin
          w_state_nxt = S_REF;
          w_issue     = 1'b1;
          w_code      = CMD_REF;
        end else if (r_state == S_PREA) begin
          w_state_nxt = S_WAIT_RP_REF;
          w_cnt_nxt   = RP_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_REF: begin
        w_state_nxt = S_WAIT_RFC;
        w_cnt_nxt   = RFC_LOAD;
      end
      S_WAIT_RFC: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter, request latch, open bits and registered command bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_open      <= '0;
      r_req_bank  <= '0;
      r_req_row   <= '0;
      r_req_col   <= '0;
      r_req_we    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
      r_cmd_all   <= 1'b0;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_cmd_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_req_bank <= req_bank;
        r_req_row  <= req_row;
        r_req_col  <= req_col;
        r_req_we   <= req_we;
      end
      r_cmd_valid <= w_issue;
      r_cmd       <= w_issue ? w_code : '0;
      r_cmd_all   <= w_issue && w_all;
      r_cmd_bank  <= (w_issue && w_code != CMD_REF && !w_all) ? w_bank : '0;
      r_cmd_row   <= (w_issue && (w_code == CMD_ACT || w_code == CMD_RW)) ? w_row : '0;
      r_cmd_col   <= (w_issue && (w_code == CMD_ACT || w_code == CMD_RW)) ? w_col : '0;
      r_cmd_we    <= w_issue && (w_code == CMD_ACT || w_code == CMD_RW) && w_we;
      if (w_issue && w_code == CMD_ACT) r_open[w_bank] <= 1'b1;
      if (w_issue && w_code == CMD_PRE) begin
        if (w_all) r_open <= '0;
        else       r_open[w_bank] <= 1'b0;
      end
    end
  end

  // Row register per bank; only meaningful while the bank's open bit is set.
  always_ff @(posedge clk) begin
    if (w_issue && w_code == CMD_ACT) r_open_row[w_bank] <= w_row;
  end

endmodule
